// File: rtl/act_stream_packer_if.sv
// Byte/word stream handshake bundle: data, valid, ready and an end-of-frame marker.
// The master drives data/valid/last, the slave answers with ready.
interface act_stream_packer_if #(
  parameter int W = 8
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/act_stream_packer.sv
// Packs LANES consecutive activation bytes into one word for the output DMA.
// The first byte received lands in the lowest lane. The last word of every
// FRAME_LEN-byte feature map carries TLAST, and a short final word is zero-padded.
// The output holds a single word. A new word may replace it in the same cycle
// it is taken, so the stream runs at one byte per cycle while the DMA keeps up.
module act_stream_packer #(
  parameter int IN_W      = 8,
  parameter int LANES     = 4,
  parameter int FRAME_LEN = 16384
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  act_stream_packer_if.slave   reluRes_V_V,
  act_stream_packer_if.master  OutDMA_V_V,
  output logic                 frame_done
);

  localparam int OUT_W  = IN_W * LANES;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic {EMPTY, FULL} outState_t;

  outState_t         outState;
  logic [LANE_W-1:0] laneCnt;
  logic [CNT_W-1:0]  byteCnt;
  logic [OUT_W-1:0]  packWord;
  logic [OUT_W-1:0]  mergedWord;
  logic [OUT_W-1:0]  outData;
  logic              outLast;

  logic inReady;
  logic acc;
  logic lastByte;
  logic closeWord;
  logic outTaken;

  // The input stream has no frame marker of its own; the packer counts bytes instead.
  logic unusedInLast;
  assign unusedInLast = reluRes_V_V.tlast;

  // Input may move whenever the output slot is free or is being emptied this cycle.
  assign inReady   = (outState == EMPTY) | OutDMA_V_V.tready;
  assign acc       = reluRes_V_V.tvalid & inReady;
  assign lastByte  = (byteCnt == CNT_W'(FRAME_LEN - 1));
  assign closeWord = (laneCnt == LANE_W'(LANES - 1)) | lastByte;
  assign outTaken  = (outState == FULL) & OutDMA_V_V.tready;

  // Drop the incoming byte into its lane. Lanes above it are still zero because
  // packWord is cleared each time a word closes, and that gives the zero padding.
  for (genvar gi = 0; gi < LANES; gi++) begin : gLane
    assign mergedWord[gi*IN_W +: IN_W] = (laneCnt == LANE_W'(gi)) ?
                                         reluRes_V_V.tdata : packWord[gi*IN_W +: IN_W];
  end

  // Pack-state and output-slot state machine. Nothing moves on a cycle without
  // acceptance, so input data is never sampled while its valid is low.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      outState   <= EMPTY;
      laneCnt    <= '0;
      byteCnt    <= '0;
      packWord   <= '0;
      outData    <= '0;
      outLast    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= outTaken & outLast;
      if (outTaken) begin
        outState <= EMPTY;
      end
      if (acc) begin
        byteCnt <= lastByte ? '0 : byteCnt + CNT_W'(1);
        if (closeWord) begin
          outData  <= mergedWord;
          outLast  <= lastByte;
          outState <= FULL;
          laneCnt  <= '0;
          packWord <= '0;
        end else begin
          laneCnt  <= laneCnt + LANE_W'(1);
          packWord <= mergedWord;
        end
      end
    end
  end

  assign reluRes_V_V.tready = inReady;
  assign OutDMA_V_V.tdata   = outData;
  assign OutDMA_V_V.tvalid  = (outState == FULL);
  assign OutDMA_V_V.tlast   = outLast;

endmodule

// File: tb/tb_act_stream_packer.sv
// Bench for act_stream_packer. Four instances with different frame lengths run
// side by side. A queue-based reference model predicts every output cycle, and
// fixed literal words check the model itself.
module tb_act_stream_packer;

  localparam int NDUT = 4;
  localparam int FL [NDUT] = '{16384, 6, 8, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  inData [NDUT];
  logic [31:0] outData [NDUT];
  logic [NDUT-1:0] inValid, dmaReady, inReady, outValid, outLast, frameDone;

  int tests = 0;
  int fails = 0;

  // Reference model state: words due on the output, partial word, frame position.
  logic [32:0] expQ   [NDUT][$];
  logic [32:0] outLog [NDUT][$];
  logic [31:0] partWord [NDUT];
  int          partN [NDUT];
  int          pos [NDUT];
  logic        doneExp [NDUT];

  for (genvar gi = 0; gi < NDUT; gi++) begin : gDut
    act_stream_packer_if #(.W(8))  inIf ();
    act_stream_packer_if #(.W(32)) outIf ();

    assign inIf.tdata    = inData[gi];
    assign inIf.tvalid   = inValid[gi];
    assign inIf.tlast    = 1'b0;
    assign inReady[gi]   = inIf.tready;
    assign outIf.tready  = dmaReady[gi];
    assign outValid[gi]  = outIf.tvalid;
    assign outData[gi]   = outIf.tdata;
    assign outLast[gi]   = outIf.tlast;

    act_stream_packer #(.IN_W(8), .LANES(4), .FRAME_LEN(FL[gi])) dut (
      .ap_clk      (clk),
      .ap_rst      (rst),
      .reluRes_V_V (inIf),
      .OutDMA_V_V  (outIf),
      .frame_done  (frameDone[gi])
    );
  end

  task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0h, expected %0h", name, k, act, exp);
    end
  endtask

  task automatic checkWord(input string name, input int k, input int idx, input logic [32:0] exp);
    if (outLog[k].size() > idx) begin
      check(name, k, 64'(outLog[k][idx]), 64'(exp));
    end else begin
      tests++;
      fails++;
      $display("FAIL %s dut%0d: got no word %0d, expected %0h", name, k, idx, exp);
    end
  endtask

  // Reference model: at each clock, retire the shown word if the DMA takes it,
  // then add the accepted byte to the running word and close it on a full word
  // or at the end of a frame.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      for (int k = 0; k < NDUT; k++) begin
        if (rst) begin
          expQ[k].delete();
          partWord[k] = '0;
          partN[k]    = 0;
          pos[k]      = 0;
          doneExp[k]  = 1'b0;
        end else begin
          logic [32:0] w;
          logic exValid, exReady;
          exValid    = (expQ[k].size() != 0);
          exReady    = !exValid || dmaReady[k];
          doneExp[k] = 1'b0;
          if (exValid && dmaReady[k]) begin
            w = expQ[k].pop_front();
            outLog[k].push_back(w);
            doneExp[k] = w[32];
          end
          if (inValid[k] && exReady) begin
            partWord[k] = partWord[k] | (32'(inData[k]) << (8 * partN[k]));
            partN[k]++;
            pos[k]++;
            if (partN[k] == 4 || pos[k] == FL[k]) begin
              expQ[k].push_back({pos[k] == FL[k], partWord[k]});
              partWord[k] = '0;
              partN[k]    = 0;
              if (pos[k] == FL[k]) pos[k] = 0;
            end
          end
        end
      end
    end
  end

  // Compare process: every cycle, away from the clock edge, each output must match the model.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        for (int k = 0; k < NDUT; k++) begin
          logic exValid;
          exValid = (expQ[k].size() != 0);
          check("tvalid", k, 64'(outValid[k]), 64'(exValid));
          check("in_tready", k, 64'(inReady[k]), 64'(!exValid || dmaReady[k]));
          check("frame_done", k, 64'(frameDone[k]), 64'(doneExp[k]));
          if (exValid) begin
            check("tdata", k, 64'(outData[k]), 64'(expQ[k][0][31:0]));
            check("tlast", k, 64'(outLast[k]), 64'(expQ[k][0][32]));
          end
        end
      end
    end
  end

  task automatic sendByte(input int k, input logic [7:0] b);
    int tries;
    tries = 0;
    @(negedge clk);
    inValid[k] = 1'b1;
    inData[k]  = b;
    #1;
    while (!inReady[k] && tries < 200) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (tries >= 200) begin
      tests++;
      fails++;
      $display("FAIL send_timeout dut%0d: got stalled byte %0h, expected acceptance", k, b);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int k, input int n);
    @(negedge clk);
    inValid[k] = 1'b0;
    inData[k]  = 8'($urandom);
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic waitDrain(input int k);
    int c;
    c = 0;
    while (expQ[k].size() != 0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (c >= 100) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout dut%0d: got %0d words pending, expected 0", k, expQ[k].size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      inData[k] = 8'h00;
    end
    inValid  = '0;
    dmaReady = '1;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check("reset_tvalid", k, 64'(outValid[k]), 64'd0);
      check("reset_tdata", k, 64'(outData[k]), 64'd0);
      check("reset_fdone", k, 64'(frameDone[k]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Test 1: four bytes back to back form one word, no TLAST.
    sendByte(0, 8'h11); sendByte(0, 8'h22); sendByte(0, 8'h33); sendByte(0, 8'h44);
    idle(0, 1);
    waitDrain(0);
    checkWord("t1_word", 0, 0, {1'b0, 32'h44332211});

    // Test 2: DMA stalls with a word held; offered bytes must wait.
    @(negedge clk);
    dmaReady[0] = 1'b0;
    sendByte(0, 8'h55); sendByte(0, 8'h66); sendByte(0, 8'h77); sendByte(0, 8'h88);
    fork
      begin
        sendByte(0, 8'h99); sendByte(0, 8'haa); sendByte(0, 8'hbb);
        sendByte(0, 8'hcc); sendByte(0, 8'hdd);
        idle(0, 1);
      end
      begin
        repeat (4) @(negedge clk);
        #1;
        check("t2_stall_ready", 0, 64'(inReady[0]), 64'd0);
        check("t2_stall_data", 0, 64'(outData[0]), 64'h88776655);
        repeat (4) @(negedge clk);
        dmaReady[0] = 1'b1;
      end
    join
    waitDrain(0);
    checkWord("t2_word1", 0, 1, {1'b0, 32'h88776655});
    checkWord("t2_word2", 0, 2, {1'b0, 32'hccbbaa99});

    // Test 3: frame of six bytes ends with a zero-padded TLAST word.
    for (int i = 1; i <= 6; i++) sendByte(1, 8'(8'h11 * i));
    idle(1, 1);
    waitDrain(1);
    checkWord("t3_word1", 1, 0, {1'b0, 32'h44332211});
    checkWord("t3_word2", 1, 1, {1'b1, 32'h00006655});

    // Test 4: two eight-byte frames with random gaps and DMA back-pressure.
    fork
      begin
        repeat (80) begin
          @(negedge clk);
          dmaReady[2] = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        dmaReady[2] = 1'b1;
      end
      begin
        for (int i = 1; i <= 16; i++) begin
          int g;
          g = $urandom_range(0, 2);
          if (g > 0) idle(2, g);
          sendByte(2, 8'(i));
        end
        idle(2, 1);
      end
    join
    waitDrain(2);
    checkWord("t4_word1", 2, 0, {1'b0, 32'h04030201});
    checkWord("t4_word2", 2, 1, {1'b1, 32'h08070605});
    checkWord("t4_word3", 2, 2, {1'b0, 32'h0c0b0a09});
    checkWord("t4_word4", 2, 3, {1'b1, 32'h100f0e0d});

    // Test 5: reset mid-word on dut1 while dut2 holds a stalled full word.
    @(negedge clk);
    dmaReady[2] = 1'b0;
    sendByte(2, 8'h21); sendByte(2, 8'h22); sendByte(2, 8'h23); sendByte(2, 8'h24);
    idle(2, 1);
    sendByte(1, 8'h01); sendByte(1, 8'h02);
    idle(1, 1);
    #1;
    check("t5_pre_valid", 2, 64'(outValid[2]), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 2, 64'(outValid[2]), 64'd0);
    check("t5_rst_data", 2, 64'(outData[2]), 64'd0);
    check("t5_rst_last", 2, 64'(outLast[2]), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dmaReady[2] = 1'b1;
    sendByte(1, 8'haa); sendByte(1, 8'hbb); sendByte(1, 8'hcc);
    sendByte(1, 8'hdd); sendByte(1, 8'hee); sendByte(1, 8'hff);
    idle(1, 1);
    waitDrain(1);
    checkWord("t5_word1", 1, 2, {1'b0, 32'hddccbbaa});
    checkWord("t5_word2", 1, 3, {1'b1, 32'h0000ffee});
    check("t5_dut2_words", 2, 64'(outLog[2].size()), 64'd4);

    // Test 6: one-byte frames, every byte its own TLAST word.
    sendByte(3, 8'h5a); sendByte(3, 8'ha5); sendByte(3, 8'hff);
    idle(3, 1);
    waitDrain(3);
    checkWord("t6_word1", 3, 0, {1'b1, 32'h0000005a});
    checkWord("t6_word2", 3, 1, {1'b1, 32'h000000a5});
    checkWord("t6_word3", 3, 2, {1'b1, 32'h000000ff});

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected end of run");
    $fatal(1, "timeout");
  end

endmodule
